// File: rtl/hazard_ctrl_if.sv
// Hazard controller pipeline interface.
// Groups the register-address, control and hazard-response signals exchanged
// between the datapath and hazard_ctrl.
//   master : datapath side; drives the pipeline fields and receives the
//            stall/flush/forward/mul-div controls and the perf counters.
//   slave  : hazard_ctrl side.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic        ResultSrcE;
  logic        PCSrcE;
  logic        MdStartE;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        FlushD;
  logic        FlushE;
  logic        FlushM;
  logic        MdCapture;
  logic        MdDone;
  logic [31:0] LdUseStallCnt;
  logic [31:0] MdStallCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, MdStartE,
           RdM, RegWriteM, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           FlushM, MdCapture, MdDone, LdUseStallCnt, MdStallCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, MdStartE,
           RdM, RegWriteM, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           FlushM, MdCapture, MdDone, LdUseStallCnt, MdStallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard and scheduling controller.
//   - Execute-stage operand forwarding selects (ForwardAE/ForwardBE).
//   - Load-use stall, taken-branch flush.
//   - Multi-cycle mul/div sequencing: the op occupies Execute MD_LATENCY
//     cycles (MD_LATENCY-1 stall cycles), MdCapture/MdDone pulses.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset; forces every output to 0
//   hz  : hazard_ctrl_if.slave, pipeline fields in, controls out
// Optional feature macro: HAZARD_PERF_EN
//   defined   -> 32-bit saturating LdUseStallCnt / MdStallCnt counters
//   undefined -> no counter flops, both outputs tied to 0
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdstall;
  logic             md_capture;
  logic             md_done;
  logic             lduse;
  logic             branch;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Mul/div sequencer
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdstall    = 1'b0;
    md_capture = 1'b0;
    md_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hz.MdStartE) begin
          md_capture = 1'b1;
          if (MD_LATENCY > 1) begin
            mdstall = 1'b1;
            cnt_d   = CNT_W'(MD_LATENCY - 2);
            state_d = BUSY;
          end else begin
            md_done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mdstall = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          md_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign lduse  = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign branch = hz.PCSrcE && !mdstall;

  // Priority: mul/div stall masks everything, then branch flush, then lduse.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.MdCapture = 1'b0;
    hz.MdDone    = 1'b0;
    if (!rst) begin
      hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      hz.MdCapture = md_capture;
      hz.MdDone    = md_done;
      if (mdstall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else if (branch) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lduse) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] lduse_cnt_q;
  logic [31:0] md_cnt_q;
  logic        lduse_applied;

  assign lduse_applied = lduse && !branch && !mdstall;

  always_ff @(posedge clk) begin
    if (rst) begin
      lduse_cnt_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      if (lduse_applied && lduse_cnt_q != '1) lduse_cnt_q <= lduse_cnt_q + 32'd1;
      if (mdstall && md_cnt_q != '1)          md_cnt_q    <= md_cnt_q + 32'd1;
    end
  end

  assign hz.LdUseStallCnt = lduse_cnt_q;
  assign hz.MdStallCnt    = md_cnt_q;
`else
  assign hz.LdUseStallCnt = '0;
  assign hz.MdStallCnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MD_LATENCY=4 main instance plus an
// MD_LATENCY=1 instance). Control outputs are compared as one vector:
// {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdCapture, MdDone}.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();
  hazard_ctrl_if hif1 ();

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  hazard_ctrl #(.MD_LATENCY(1), .CNT_W(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .hz  (hif1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE,
            hif.FlushM, hif.MdCapture, hif.MdDone};
  endfunction

  function automatic logic [7:0] ctl1();
    return {hif1.StallF, hif1.StallD, hif1.StallE, hif1.FlushD, hif1.FlushE,
            hif1.FlushM, hif1.MdCapture, hif1.MdDone};
  endfunction

  task automatic clear_inputs();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
    hif.RdE = 5'd0; hif.ResultSrcE = 1'b0; hif.PCSrcE = 1'b0; hif.MdStartE = 1'b0;
    hif.RdM = 5'd0; hif.RegWriteM = 1'b0; hif.RdW = 5'd0; hif.RegWriteW = 1'b0;
    hif1.Rs1D = 5'd0; hif1.Rs2D = 5'd0; hif1.Rs1E = 5'd0; hif1.Rs2E = 5'd0;
    hif1.RdE = 5'd0; hif1.ResultSrcE = 1'b0; hif1.PCSrcE = 1'b0; hif1.MdStartE = 1'b0;
    hif1.RdM = 5'd0; hif1.RegWriteM = 1'b0; hif1.RdW = 5'd0; hif1.RegWriteW = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] C_NONE   = 8'b0000_0000;
  localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
  localparam logic [7:0] C_BRANCH = 8'b0001_1000;
  localparam logic [7:0] C_MDCAP  = 8'b1110_0110;
  localparam logic [7:0] C_MDSTL  = 8'b1110_0100;
  localparam logic [7:0] C_MDDONE = 8'b0000_0001;
  localparam logic [7:0] C_MD1    = 8'b0000_0011;

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Hazardous inputs while in reset: outputs must still be 0.
    hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.Rs1E = 5'd5; hif.Rs2E = 5'd5;
    hif.ResultSrcE = 1'b1; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
    hif.MdStartE = 1'b1; hif.PCSrcE = 1'b1;
    hif1.MdStartE = 1'b1;
    next(); next();
    settle();
    check("rst_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
    check("rst_fwd", {28'd0, hif.ForwardAE, hif.ForwardBE}, 32'd0);
    check("rst_ctl1", {24'd0, ctl1()}, {24'd0, C_NONE});
    check("rst_ldcnt", hif.LdUseStallCnt, 32'd0);
    check("rst_mdcnt", hif.MdStallCnt, 32'd0);
    next();
    clear_inputs();
    rst = 1'b0;

    // Forwarding: M beats W; W when M not writing; x0 never forwarded.
    hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
    hif.Rs1E = 5'd5; hif.Rs2E = 5'd0;
    settle();
    check("fwd_m_a", {30'd0, hif.ForwardAE}, 32'd2);
    check("fwd_m_b", {30'd0, hif.ForwardBE}, 32'd0);
    check("fwd_noctl", {24'd0, ctl()}, {24'd0, C_NONE});
    next();
    hif.RegWriteM = 1'b0;
    settle();
    check("fwd_w_a", {30'd0, hif.ForwardAE}, 32'd1);
    next();
    hif.RegWriteM = 1'b1; hif.RdM = 5'd9; hif.RdW = 5'd3; hif.Rs1E = 5'd3; hif.Rs2E = 5'd9;
    settle();
    check("fwd_mix", {28'd0, hif.ForwardAE, hif.ForwardBE}, 32'b0110);
    next();
    hif.RdM = 5'd0; hif.RdW = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
    settle();
    check("fwd_x0", {28'd0, hif.ForwardAE, hif.ForwardBE}, 32'd0);
    next();
    clear_inputs();

    // Load-use
    hif.ResultSrcE = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    settle();
    check("lduse_rs2", {24'd0, ctl()}, {24'd0, C_LDUSE});
    next();
    hif.Rs2D = 5'd0; hif.Rs1D = 5'd7;
    settle();
    check("lduse_rs1", {24'd0, ctl()}, {24'd0, C_LDUSE});
    next();
    hif.RdE = 5'd0; hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
    settle();
    check("lduse_x0", {24'd0, ctl()}, {24'd0, C_NONE});
    next();
    hif.RdE = 5'd7; hif.Rs1D = 5'd6; hif.Rs2D = 5'd8;
    settle();
    check("lduse_nomatch", {24'd0, ctl()}, {24'd0, C_NONE});
    next();
    hif.Rs2D = 5'd7; hif.ResultSrcE = 1'b0;
    settle();
    check("lduse_notload", {24'd0, ctl()}, {24'd0, C_NONE});
    next();
    // Branch overrides load-use
    hif.ResultSrcE = 1'b1; hif.PCSrcE = 1'b1;
    settle();
    check("br_lduse", {24'd0, ctl()}, {24'd0, C_BRANCH});
    next();
    hif.ResultSrcE = 1'b0;
    settle();
    check("br_only", {24'd0, ctl()}, {24'd0, C_BRANCH});
    next();
    clear_inputs();
    settle();
`ifdef HAZARD_PERF_EN
    check("ldcnt_after", hif.LdUseStallCnt, 32'd2);
`else
    check("ldcnt_off", hif.LdUseStallCnt, 32'd0);
`endif

    // Back-to-back mul/div, branch pulsed during BUSY (cycle 1)
    next();
    hif.MdStartE = 1'b1;
    for (int unsigned c = 0; c < 9; c++) begin
      logic [7:0] exp;
      hif.PCSrcE = (c == 1);
      if (c == 8) hif.MdStartE = 1'b0;
      case (c)
        0, 4:    exp = C_MDCAP;
        1, 2, 5, 6: exp = C_MDSTL;
        3, 7:    exp = C_MDDONE;
        default: exp = C_NONE;
      endcase
      settle();
      check($sformatf("md_c%0d", c), {24'd0, ctl()}, {24'd0, exp});
      next();
    end
    clear_inputs();
    settle();
`ifdef HAZARD_PERF_EN
    check("mdcnt_2ops", hif.MdStallCnt, 32'd6);
`else
    check("mdcnt_off", hif.MdStallCnt, 32'd0);
`endif

    // MD_LATENCY=1: capture and done together, no stall, stays IDLE
    next();
    hif1.MdStartE = 1'b1;
    settle();
    check("md1_c0", {24'd0, ctl1()}, {24'd0, C_MD1});
    next();
    settle();
    check("md1_c1", {24'd0, ctl1()}, {24'd0, C_MD1});
    next();
    hif1.MdStartE = 1'b0;
    settle();
    check("md1_idle", {24'd0, ctl1()}, {24'd0, C_NONE});
    next();

    // Reset mid-BUSY
    hif.MdStartE = 1'b1;
    settle();
    check("rstb_c0", {24'd0, ctl()}, {24'd0, C_MDCAP});
    next();
    rst = 1'b1;
    settle();
    check("rstb_c1", {24'd0, ctl()}, {24'd0, C_NONE});
    next();
    rst = 1'b0;
    hif.MdStartE = 1'b0;
    settle();
    check("rstb_idle", {24'd0, ctl()}, {24'd0, C_NONE});
    check("rstb_mdcnt", hif.MdStallCnt, 32'd0);
    next();
    hif.MdStartE = 1'b1;
    settle();
    check("rstb_new_c0", {24'd0, ctl()}, {24'd0, C_MDCAP});
    next(); next(); next();
    hif.MdStartE = 1'b0;
    settle();
`ifdef HAZARD_PERF_EN
    check("rstb_mdcnt_op", hif.MdStallCnt, 32'd3);
`else
    check("rstb_mdcnt_off", hif.MdStallCnt, 32'd0);
`endif
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and scheduling controller for the 5-stage pipeline. It generates the Execute-stage operand forwarding selects (ForwardAE/ForwardBE) and resolves load-use and taken-branch hazards with stalls and flushes. It also sequences multi-cycle multiply/divide ops that occupy Execute for MD_LATENCY cycles.
It sits beside the datapath and drives the stall/flush enables of the F/D/E/M pipeline registers.

Parameters:
MD_LATENCY, 4, total cycles a multi-cycle op occupies Execute; legal range 1..16.
CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W >= MD_LATENCY.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
Rs1D  in  5  rs1 of the instruction in Decode
Rs2D  in  5  rs2 of the instruction in Decode
Rs1E  in  5  rs1 of the instruction in Execute
Rs2E  in  5  rs2 of the instruction in Execute
RdE  in  5  rd of the instruction in Execute
ResultSrcE  in  1  Execute instruction is a load
PCSrcE  in  1  taken branch/jump resolved in Execute
MdStartE  in  1  Execute instruction is a multi-cycle mul/div
RdM  in  5  rd in Memory
RegWriteM  in  1  Memory instruction writes the register file
RdW  in  5  rd in Writeback
RegWriteW  in  1  Writeback instruction writes the register file
ForwardAE  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold the F/D register
StallE  out  1  hold the D/E register
FlushD  out  1  clear the F/D register
FlushE  out  1  clear the D/E register (bubble)
FlushM  out  1  clear the E/M register (bubble)
MdCapture  out  1  one-cycle pulse: mul/div unit latches its operands
MdDone  out  1  one-cycle pulse: mul/div result valid this cycle
LdUseStallCnt  out  32  load-use stall cycle count (optional feature)
MdStallCnt  out  32  mul/div stall cycle count (optional feature)

Behaviour:
- Forwarding is combinational and evaluated independently for A (Rs1E) and B (Rs2E).
  - Select 10 if RegWriteM, RdM != 0 and RdM == RsxE.
  - Otherwise select 01 if RegWriteW, RdW != 0 and RdW == RsxE.
  - Otherwise select 00. M wins over W when both match.
- Load-use hazard: lduse = ResultSrcE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D). When set: StallF = StallD = 1, FlushE = 1.
- Branch: when PCSrcE is set and mdstall = 0: FlushD = 1, FlushE = 1. Branch flush overrides the lduse stall: StallF/StallD = 0 in that cycle.
- Mul/div FSM: states IDLE and BUSY, with a counter cnt of width CNT_W.
  - IDLE, MdStartE = 1, MD_LATENCY > 1: mdstall = 1, MdCapture = 1, cnt <= MD_LATENCY-2, go to BUSY.
  - IDLE, MdStartE = 1, MD_LATENCY == 1: MdCapture = 1 and MdDone = 1 in the same cycle; no stall; stay in IDLE.
  - BUSY, cnt != 0: mdstall = 1, cnt <= cnt-1.
  - BUSY, cnt == 0: mdstall = 0, MdDone = 1, go to IDLE.
  - Result: the op sits in Execute exactly MD_LATENCY cycles, with MD_LATENCY-1 stall cycles.
  - Back-to-back mul/div: MdStartE is high in the cycle after IDLE is re-entered, so a new sequence starts; there is no gap cycle.
- Stall outputs while mdstall = 1:
  - StallF = StallD = StallE = 1 and FlushM = 1.
  - FlushD = FlushE = 0; the lduse and branch terms are masked.
- Forwarding is unaffected by mdstall. The mul/div unit must use the operands captured on MdCapture, because M/W contents drain during the stall.
- Reset (rst = 1, also when asserted mid-BUSY):
  - Next state is IDLE, cnt = 0.
  - While rst is high, every output is forced to 0: all Stall*, Flush*, Md* and ForwardxE = 00.
  - The first post-reset cycle evaluates normally.

Optional Feature:
HAZARD_PERF_EN:
- Defined: two 32-bit saturating counters, reset to 0.
  - LdUseStallCnt increments on each cycle where the lduse stall is actually applied (not overridden by branch, not masked by mdstall).
  - MdStallCnt increments on each cycle with mdstall = 1.
  - Both hold at 0xFFFFFFFF.
- Undefined: no counter flops; both outputs are tied to 0.

Test Plan:
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5, Rs2E = 0 -> ForwardAE = 10, ForwardBE = 00. Then RegWriteM = 0 -> ForwardAE = 01.
- Load-use: ResultSrcE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for 1 cycle. Same with RdE = 0 -> no stall.
- Branch + load-use coincident: PCSrcE = 1, lduse true -> FlushD = FlushE = 1, StallF = StallD = 0.
- Mul/div, MD_LATENCY = 4: MdStartE held high -> MdCapture in cycle 0; StallF/D/E = FlushM = 1 in cycles 0-2; MdDone in cycle 3. With MD_LATENCY = 1 -> MdCapture = MdDone = 1 in cycle 0, no stall.
- Back-to-back mul/div plus a branch during BUSY: PCSrcE pulsed in cycle 1 -> no FlushD/FlushE. Second op: MdCapture in cycle 4, MdDone in cycle 7.
- Reset mid-BUSY: rst in cycle 1 -> all outputs 0 that cycle, state IDLE. With HAZARD_PERF_EN: MdStallCnt = 0 after reset, then counts 3 per 4-cycle op.
